// File: rtl/chess_layout_scanner.sv
// chess_layout_scanner: snapshots a 64-square board and streams it square by square to an LCD drawer over valid/ready.
// Define CHESS_SCAN_DIRTY_ONLY_EN to emit only squares that changed since the last transferred frame.
module chess_layout_scanner #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetApp_n,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    start,
  input  logic                    drawReady,
  output logic                    drawValid,
  output logic [2:0]              drawX,
  output logic [2:0]              drawY,
  output logic [3:0]              drawPiece,
  output logic [3:0]              drawSelect,
  output logic                    drawLast,
  output logic                    busy,
  output logic                    frameDone
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [MATRIX_WIDTH-1:0] snap_q, snap_d;
  logic [SQUARE_WIDTH-1:0] sq;
  logic emit, last;
  logic draw_valid_q, draw_valid_d, draw_last_q, draw_last_d;
  logic [2:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic [3:0] draw_piece_q, draw_piece_d, draw_select_q, draw_select_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d;
  assign sq = snap_q[int'(idx_q) * SQUARE_WIDTH +: SQUARE_WIDTH];
  assign last = &idx_q;
`ifdef CHESS_SCAN_DIRTY_ONLY_EN
  logic [SQUARE_WIDTH-1:0] store_q [CHESS_SQUARES];
  logic [CHESS_SQUARES-1:0] seen_q, seen_d;
  logic xfer;
  assign xfer = state_q == EMIT && drawReady;
  assign emit = !seen_q[idx_q] || store_q[idx_q] != sq;
  always_comb begin
    seen_d = seen_q;
    if (xfer) seen_d[idx_q] = 1'b1;
  end
  // history contents need no reset: the seen bits gate every use of them
  always_ff @(posedge clock) if (xfer) store_q[idx_q] <= sq;
  always_ff @(posedge clock or negedge resetApp_n)
    if (!resetApp_n) seen_q <= '0;
    else seen_q <= seen_d;
`else
  assign emit = 1'b1;
`endif
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    draw_valid_d  = draw_valid_q;
    draw_x_d      = draw_x_q;
    draw_y_d      = draw_y_q;
    draw_piece_d  = draw_piece_q;
    draw_select_d = draw_select_q;
    draw_last_d   = draw_last_q;
    case (state_q)
      IDLE: if (start) begin
        snap_d  = Layout;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: if (emit) begin
        draw_valid_d  = 1'b1;
        draw_x_d      = idx_q[2:0];
        draw_y_d      = idx_q[5:3];
        draw_piece_d  = sq[3:0];
        draw_select_d = sq[7:4];
        draw_last_d   = last;
        state_d       = EMIT;
      end else begin
        state_d = last ? DONE : SCAN;
        idx_d   = last ? idx_q : idx_q + 6'd1;
      end
      EMIT: if (drawReady) begin
        draw_valid_d = 1'b0;
        state_d      = last ? DONE : SCAN;
        idx_d        = last ? idx_q : idx_q + 6'd1;
      end
      DONE: state_d = IDLE;
    endcase
    busy_d       = state_d != IDLE;
    frame_done_d = state_d == DONE;
  end
  always_ff @(posedge clock or negedge resetApp_n)
    if (!resetApp_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      draw_valid_q  <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_piece_q  <= '0;
      draw_select_q <= '0;
      draw_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      draw_valid_q  <= draw_valid_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      draw_piece_q  <= draw_piece_d;
      draw_select_q <= draw_select_d;
      draw_last_q   <= draw_last_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  assign drawValid  = draw_valid_q;
  assign drawX      = draw_x_q;
  assign drawY      = draw_y_q;
  assign drawPiece  = draw_piece_q;
  assign drawSelect = draw_select_q;
  assign drawLast   = draw_last_q;
  assign busy       = busy_q;
  assign frameDone  = frame_done_q;
endmodule

// File: tb/tb_chess_layout_scanner.sv
// tb_chess_layout_scanner: directed bench for chess_layout_scanner; transfers are logged as {x,y,piece,select,last}.
module tb_chess_layout_scanner;
  logic clock = 1'b0, resetApp_n = 1'b0, start = 1'b0, drawReady = 1'b0;
  logic [511:0] Layout = '0;
  logic drawValid, drawLast, busy, frameDone;
  logic [2:0] drawX, drawY;
  logic [3:0] drawPiece, drawSelect;
  logic [14:0] xf[$];
  int done_cnt = 0, checks = 0, fails = 0;
  always #5 clock = ~clock;
  chess_layout_scanner dut (
    .clock(clock), .resetApp_n(resetApp_n), .Layout(Layout), .start(start), .drawReady(drawReady),
    .drawValid(drawValid), .drawX(drawX), .drawY(drawY), .drawPiece(drawPiece), .drawSelect(drawSelect),
    .drawLast(drawLast), .busy(busy), .frameDone(frameDone)
  );
  always @(negedge clock) begin
    if (drawValid && drawReady) xf.push_back({drawX, drawY, drawPiece, drawSelect, drawLast});
    if (frameDone) done_cnt++;
  end
  function automatic logic [511:0] mk(input int k);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(i * 5 + k);
    return r;
  endfunction
  function automatic logic [14:0] ex(input logic [511:0] l, input int i);
    logic [7:0] s;
    s = l[i*8 +: 8];
    return {3'(i), 3'(i >> 3), s[3:0], s[7:4], i == 63};
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic kick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic do_reset;
    resetApp_n = 1'b0;
    start = 1'b0;
    drawReady = 1'b0;
    tick;
    tick;
    resetApp_n = 1'b1;
    tick;
    xf.delete();
    done_cnt = 0;
  endtask
  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int n = 0; n < budget && done_cnt == d0; n++) tick;
    if (done_cnt == d0) begin
      checks++;
      fails++;
      $display("FAIL wait_done timeout after %0d cycles, frameDone never pulsed", budget);
    end
  endtask
  task automatic test_reset;
    resetApp_n = 1'b0;
    #1;
    checks++;
    if ({drawValid, drawX, drawY, drawPiece, drawSelect, drawLast, busy, frameDone} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h required 0", {drawValid, drawX, drawY, drawPiece, drawSelect, drawLast, busy, frameDone});
    end
    resetApp_n = 1'b1;
    drawReady = 1'b1;
    tick;
    tick;
    checks++;
    if ({busy, drawValid, frameDone} !== 3'b000) begin
      fails++;
      $display("FAIL idle_no_start busy/valid/done=%b required 000", {busy, drawValid, frameDone});
    end
  endtask
  task automatic test_full_scan;
    logic [511:0] l;
    l = mk(0);
    l[7:0] = 8'h05;
    l[511:504] = 8'h1A;
    do_reset;
    Layout = l;
    drawReady = 1'b1;
    kick;
    checks++;
    if ({drawValid, busy} !== 2'b01) begin
      fails++;
      $display("FAIL scan_cycle valid=%b busy=%b required valid=0 busy=1", drawValid, busy);
    end
    tick;
    checks++;
    if ({drawValid, drawX, drawY, drawPiece, drawLast} !== {1'b1, 3'd0, 3'd0, 4'h5, 1'b0}) begin
      fails++;
      $display("FAIL first_valid got v=%b x=%0d y=%0d p=%h l=%b required v=1 x=0 y=0 p=5 l=0", drawValid, drawX, drawY, drawPiece, drawLast);
    end
    wait_done(300);
    checks++;
    if (xf.size() != 64) begin
      fails++;
      $display("FAIL full_count got %0d required 64", xf.size());
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (xf[i] !== ex(l, i)) begin
        fails++;
        $display("FAIL full_entry[%0d] got %h required %h", i, xf[i], ex(l, i));
      end
    end
    checks++;
    if (xf[63] !== {3'd7, 3'd7, 4'hA, 4'h1, 1'b1}) begin
      fails++;
      $display("FAIL last_entry got %h required %h", xf[63], {3'd7, 3'd7, 4'hA, 4'h1, 1'b1});
    end
  endtask
  task automatic test_stall;
    logic [511:0] l;
    logic [14:0] e;
    bit found = 0;
    l = mk(17);
    e = ex(l, 10);
    do_reset;
    Layout = l;
    drawReady = 1'b1;
    kick;
    for (int n = 0; n < 100 && !found; n++) begin
      tick;
      found = drawValid && drawX == 3'd2 && drawY == 3'd1;
    end
    drawReady = 1'b0;
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL stall_search square 10 never presented");
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({drawValid, drawX, drawY, drawPiece, drawSelect, drawLast} !== {1'b1, e}) begin
        fails++;
        $display("FAIL stall_hold[%0d] got %h required %h", k, {drawValid, drawX, drawY, drawPiece, drawSelect, drawLast}, {1'b1, e});
      end
      tick;
    end
    drawReady = 1'b1;
    tick;
    checks++;
    if (drawValid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release valid=%b required 0", drawValid);
    end
    wait_done(300);
    checks++;
    if (xf.size() != 64 || xf[10] !== e) begin
      fails++;
      $display("FAIL stall_transfer count=%0d entry10=%h required 64 and %h", xf.size(), xf[10], e);
    end
  endtask
  task automatic test_layout_change;
    logic [511:0] l;
    int bad = 0;
    l = mk(40);
    do_reset;
    Layout = l;
    drawReady = 1'b1;
    kick;
    Layout = ~l;
    wait_done(300);
    for (int i = 0; i < 64; i++) if (xf[i] !== ex(l, i)) bad++;
    checks++;
    if (xf.size() != 64 || bad != 0) begin
      fails++;
      $display("FAIL snapshot count=%0d wrong_entries=%0d required 64 and 0", xf.size(), bad);
    end
  endtask
  task automatic test_back_to_back;
    do_reset;
    Layout = mk(90);
    drawReady = 1'b1;
    kick;
    for (int n = 0; n < 300 && !frameDone; n++) begin
      start = ~start;
      tick;
    end
    checks++;
    if ({frameDone, busy} !== 2'b11) begin
      fails++;
      $display("FAIL done_state frameDone=%b busy=%b required 1 1", frameDone, busy);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({frameDone, busy} !== 2'b00) begin
      fails++;
      $display("FAIL after_done frameDone=%b busy=%b required 0 0", frameDone, busy);
    end
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || xf.size() != 64 || done_cnt != 1) begin
      fails++;
      $display("FAIL single_scan busy=%b transfers=%0d frames=%0d required 0 64 1", busy, xf.size(), done_cnt);
    end
  endtask
  task automatic test_reset_mid;
    logic [511:0] l;
    bit found = 0;
    int n0;
    l = mk(130);
    do_reset;
    Layout = l;
    drawReady = 1'b1;
    kick;
    for (int n = 0; n < 200 && !found; n++) begin
      tick;
      found = drawValid && drawX == 3'd6 && drawY == 3'd3;
    end
    resetApp_n = 1'b0;
    #1;
    checks++;
    if (!found || {drawValid, drawX, drawY, drawPiece, drawSelect, drawLast, busy, frameDone} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid found=%b outputs=%h required 1 and 0", found, {drawValid, drawX, drawY, drawPiece, drawSelect, drawLast, busy, frameDone});
    end
    n0 = xf.size();
    tick;
    tick;
    checks++;
    if (n0 != 30 || xf.size() != n0) begin
      fails++;
      $display("FAIL reset_abort before=%0d after=%0d required 30 30", n0, xf.size());
    end
    resetApp_n = 1'b1;
    tick;
    xf.delete();
    kick;
    wait_done(300);
    checks++;
    if (xf.size() != 64 || xf[0] !== ex(l, 0)) begin
      fails++;
      $display("FAIL restart count=%0d first=%h required 64 and %h", xf.size(), xf[0], ex(l, 0));
    end
  endtask
`ifdef CHESS_SCAN_DIRTY_ONLY_EN
  task automatic test_dirty;
    logic [511:0] l;
    int d0;
    l = mk(0);
    do_reset;
    Layout = l;
    drawReady = 1'b1;
    kick;
    wait_done(300);
    checks++;
    if (xf.size() != 64) begin
      fails++;
      $display("FAIL dirty_first count=%0d required 64", xf.size());
    end
    xf.delete();
    l[19*8 +: 8] = 8'h13;
    Layout = l;
    kick;
    wait_done(300);
    checks++;
    if (xf.size() != 1 || xf[0] !== {3'd3, 3'd2, 4'h3, 4'h1, 1'b0}) begin
      fails++;
      $display("FAIL dirty_one count=%0d entry=%h required 1 and %h", xf.size(), xf[0], {3'd3, 3'd2, 4'h3, 4'h1, 1'b0});
    end
    xf.delete();
    d0 = done_cnt;
    kick;
    wait_done(300);
    checks++;
    if (xf.size() != 0 || done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL dirty_none count=%0d frames=%0d required 0 %0d", xf.size(), done_cnt, d0 + 1);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_full_scan;
    test_stall;
    test_layout_change;
    test_back_to_back;
    test_reset_mid;
`ifdef CHESS_SCAN_DIRTY_ONLY_EN
    test_dirty;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
